// File: rtl/adpll_grid_sequencer_if.sv
// Control/status bundle between the top-level switch logic and the ADPLL mesh sequencer.
// The sequencer connects through the slave modport; the controlling side uses master.
interface adpll_grid_sequencer_if #(
    parameter int ROWS       = 2,
    parameter int COLS       = 2,
    parameter int PDET_WIDTH = 8
);
    localparam int N         = ROWS * COLS;
    localparam int IDX_WIDTH = (N > 1) ? $clog2(N) : 1;

    logic                    enable_i;
    logic                    uni_dir_i;
    logic [N*PDET_WIDTH-1:0] error_i;
    logic [N-1:0]            node_enable_o;
    logic [N*16-1:0]         weights_o;
    logic [N-1:0]            locked_o;
    logic                    all_locked_o;
    logic                    fault_o;
    logic                    lost_lock_o;
    logic [IDX_WIDTH-1:0]    active_node_o;
    logic [1:0]              state_o;

    modport master (
        output enable_i, uni_dir_i, error_i,
        input  node_enable_o, weights_o, locked_o, all_locked_o,
               fault_o, lost_lock_o, active_node_o, state_o
    );

    modport slave (
        input  enable_i, uni_dir_i, error_i,
        output node_enable_o, weights_o, locked_o, all_locked_o,
               fault_o, lost_lock_o, active_node_o, state_o
    );
endinterface

// File: rtl/adpll_grid_sequencer.sv
// Raster-order bring-up, lock detection and neighbour weighting for a ROWS x COLS ADPLL mesh.
// Nodes are enabled one at a time; each must lock before the next one starts.
module adpll_grid_sequencer #(
    parameter int ROWS           = 2,
    parameter int COLS           = 2,
    parameter int PDET_WIDTH     = 8,
    parameter int LOCK_THRESH    = 4,
    parameter int LOCK_CYCLES    = 1024,
    parameter int TIMEOUT_CYCLES = 65536,
    parameter int CNT_WIDTH      = 17
) (
    input  logic                 fpga_clk_i,
    input  logic                 rst_n_i,
    adpll_grid_sequencer_if.slave bus
);
    localparam int N         = ROWS * COLS;
    localparam int IDX_WIDTH = (N > 1) ? $clog2(N) : 1;

    typedef enum logic [1:0] {
        ST_IDLE    = 2'd0,
        ST_BRINGUP = 2'd1,
        ST_RUN     = 2'd2,
        ST_FAULT   = 2'd3
    } state_e;

    localparam logic [IDX_WIDTH-1:0] LAST_IDX = IDX_WIDTH'(N - 1);
    localparam logic [CNT_WIDTH-1:0] LOCK_MAX = CNT_WIDTH'(LOCK_CYCLES);
    localparam logic [CNT_WIDTH-1:0] TMO_LAST = CNT_WIDTH'(TIMEOUT_CYCLES - 1);
    localparam logic [PDET_WIDTH:0]  THRESH   = (PDET_WIDTH + 1)'(LOCK_THRESH);

    // One extra bit keeps the most-negative error at 2^(PDET_WIDTH-1) instead of wrapping.
    function automatic logic in_window(input logic [PDET_WIDTH-1:0] err);
        logic [PDET_WIDTH:0] mag;
        if (err[PDET_WIDTH-1]) begin
            mag = {1'b0, ~err} + {{PDET_WIDTH{1'b0}}, 1'b1};
        end else begin
            mag = {1'b0, err};
        end
        return (mag <= THRESH);
    endfunction

    function automatic logic [15:0] node_weights(input int n,
                                                 input logic [N+COLS-1:0] en_pad,
                                                 input logic uni);
        int         r;
        int         c;
        logic       u_left;
        logic       u_above;
        logic       d_right;
        logic       d_below;
        logic [3:0] u_sh;
        logic [3:0] d_sh;
        r       = n / COLS;
        c       = n % COLS;
        u_left  = (r == 0) || (c > 0);
        u_above = (r > 0);
        d_right = !uni && (c < COLS - 1) && en_pad[n + 1];
        d_below = !uni && (r < ROWS - 1) && en_pad[n + COLS];
        if (!d_right && !d_below) begin
            u_sh = (u_left && u_above) ? 4'd2 : 4'd4;
            d_sh = 4'd0;
        end else begin
            u_sh = (u_left && u_above) ? 4'd1 : 4'd2;
            d_sh = (d_right && d_below) ? 4'd1 : 4'd2;
        end
        if (!en_pad[n]) begin
            return 16'h0000;
        end else begin
            return {u_left  ? u_sh : 4'd0, u_above ? u_sh : 4'd0,
                    d_right ? d_sh : 4'd0, d_below ? d_sh : 4'd0};
        end
    endfunction

    state_e               state_q, state_d;
    logic [IDX_WIDTH-1:0] k_q, k_d;
    logic [N-1:0]         en_q, en_d;
    logic [N-1:0]         locked_q, locked_d;
    logic [N-1:0]         lock_prev_q;
    logic [CNT_WIDTH-1:0] cnt_q [N];
    logic [CNT_WIDTH-1:0] cnt_d [N];
    logic [CNT_WIDTH-1:0] tmo_q, tmo_d;
    logic [N*16-1:0]      weights_q, weights_d;
    logic                 all_locked_q, all_locked_d;
    logic                 fault_q, fault_d;
    logic                 lost_q, lost_d;

    // FSM state register
    always_ff @(posedge fpga_clk_i or negedge rst_n_i) begin
        if (!rst_n_i) begin
            state_q <= ST_IDLE;
        end else begin
            state_q <= state_d;
        end
    end

    // FSM next state; dropping enable_i overrides any lock or timeout event
    always_comb begin
        state_d = state_q;
        if (!bus.enable_i) begin
            state_d = ST_IDLE;
        end else begin
            case (state_q)
                ST_IDLE:    state_d = ST_BRINGUP;
                ST_BRINGUP: begin
                    if (locked_q[k_q]) begin
                        state_d = (k_q == LAST_IDX) ? ST_RUN : ST_BRINGUP;
                    end else if (tmo_q == TMO_LAST) begin
                        state_d = ST_FAULT;
                    end else begin
                        state_d = ST_BRINGUP;
                    end
                end
                ST_RUN:     state_d = ST_RUN;
                ST_FAULT:   state_d = ST_FAULT;
                default:    state_d = ST_IDLE;
            endcase
        end
    end

    // Next values for enables, lock counters, timeout and all registered outputs
    always_comb begin
        k_d       = k_q;
        en_d      = en_q;
        tmo_d     = tmo_q;
        locked_d  = '0;
        weights_d = '0;
        for (int n = 0; n < N; n++) begin
            cnt_d[n] = '0;
        end
        if (!bus.enable_i) begin
            k_d   = '0;
            en_d  = '0;
            tmo_d = '0;
        end else begin
            case (state_q)
                ST_IDLE: begin
                    k_d     = '0;
                    en_d    = '0;
                    en_d[0] = 1'b1;
                    tmo_d   = '0;
                end
                ST_BRINGUP: begin
                    if (locked_q[k_q]) begin
                        tmo_d = '0;
                        if (k_q != LAST_IDX) begin
                            k_d       = k_q + 1'b1;
                            en_d[k_d] = 1'b1;
                        end else begin
                            k_d = k_q;
                        end
                    end else begin
                        tmo_d = tmo_q + 1'b1;
                    end
                end
                ST_RUN:   k_d = k_q;
                ST_FAULT: k_d = k_q;
                default: begin
                    k_d   = '0;
                    en_d  = '0;
                    tmo_d = '0;
                end
            endcase
        end
        for (int n = 0; n < N; n++) begin
            if (bus.enable_i && en_q[n] &&
                in_window(bus.error_i[n*PDET_WIDTH +: PDET_WIDTH])) begin
                cnt_d[n] = (cnt_q[n] == LOCK_MAX) ? LOCK_MAX : cnt_q[n] + 1'b1;
            end else begin
                cnt_d[n] = '0;
            end
            locked_d[n]           = (cnt_d[n] == LOCK_MAX);
            weights_d[n*16 +: 16] = node_weights(n, {{COLS{1'b0}}, en_d}, bus.uni_dir_i);
        end
        all_locked_d = (state_d == ST_RUN) && (&locked_d);
        fault_d      = (state_d == ST_FAULT);
        // A lock drop is seen one edge late via lock_prev_q, so lost_lock follows locked_o by one edge.
        if (!bus.enable_i) begin
            lost_d = 1'b0;
        end else begin
            lost_d = lost_q | ((state_q == ST_RUN) && (|(lock_prev_q & ~locked_q)));
        end
    end

    // Datapath and output registers
    always_ff @(posedge fpga_clk_i or negedge rst_n_i) begin
        if (!rst_n_i) begin
            k_q          <= '0;
            en_q         <= '0;
            tmo_q        <= '0;
            locked_q     <= '0;
            lock_prev_q  <= '0;
            weights_q    <= '0;
            all_locked_q <= 1'b0;
            fault_q      <= 1'b0;
            lost_q       <= 1'b0;
            for (int n = 0; n < N; n++) begin
                cnt_q[n] <= '0;
            end
        end else begin
            k_q          <= k_d;
            en_q         <= en_d;
            tmo_q        <= tmo_d;
            locked_q     <= locked_d;
            lock_prev_q  <= locked_q;
            weights_q    <= weights_d;
            all_locked_q <= all_locked_d;
            fault_q      <= fault_d;
            lost_q       <= lost_d;
            for (int n = 0; n < N; n++) begin
                cnt_q[n] <= cnt_d[n];
            end
        end
    end

    assign bus.node_enable_o = en_q;
    assign bus.weights_o     = weights_q;
    assign bus.locked_o      = locked_q;
    assign bus.all_locked_o  = all_locked_q;
    assign bus.fault_o       = fault_q;
    assign bus.lost_lock_o   = lost_q;
    assign bus.active_node_o = k_q;
    assign bus.state_o       = state_q;
endmodule

// File: doc/adpll_grid_sequencer.md
# adpll_grid_sequencer

Parametrised bring-up and weighting controller for a ROWS x COLS mesh of NetworkADPLL nodes. It enables nodes one at a time in raster order, waits for each node to lock before enabling the next, and generates every node's four 4-bit neighbour weights from grid position, mode and which neighbours are live. It reports per-node and global lock status and flags timeout faults and loss of lock. It sits between the top-level switch/reference logic and the ADPLL mesh, replacing hard-wired weight selection and the shared enable.

## Interface
- ROWS, 2, mesh rows (>=1)
- COLS, 2, mesh columns (>=1)
- PDET_WIDTH, 8, phase-detector error width, two's complement
- LOCK_THRESH, 4, max |error| counted as in-window
- LOCK_CYCLES, 1024, consecutive in-window cycles required for lock
- TIMEOUT_CYCLES, 65536, cycles allowed per node to lock during bring-up
- CNT_WIDTH, 17, counter width; must hold max(LOCK_CYCLES, TIMEOUT_CYCLES)

N = ROWS*COLS; node n = r*COLS + c; IDX_WIDTH = max(1, clog2(N)).
- fpga_clk_i  in  1  single clock
- rst_n_i  in  1  asynchronous, active-low reset
- enable_i  in  1  start bring-up when high; low aborts and clears
- uni_dir_i  in  1  1 = upstream-only weighting, 0 = bidirectional
- error_i  in  N*PDET_WIDTH  node n error_left at [n*PDET_WIDTH +: PDET_WIDTH]
- node_enable_o  out  N  per-node ADPLL enable
- weights_o  out  N*16  node n at [n*16 +: 16] = {left[15:12], above[11:8], right[7:4], below[3:0]}
- locked_o  out  N  per-node lock
- all_locked_o  out  1  AND of locked_o, valid only in RUN, else 0
- fault_o  out  1  bring-up timeout
- lost_lock_o  out  1  sticky: a node lost lock in RUN
- active_node_o  out  IDX_WIDTH  node currently being brought up
- state_o  out  2  IDLE=0, BRINGUP=1, RUN=2, FAULT=3

## Operation
- FSM: IDLE -> (enable_i) BRINGUP, k=0 -> on locked_o[k]: k<N-1 enables k+1, k=N-1 goes to RUN. Timeout counter reaching TIMEOUT_CYCLES with locked_o[k] low -> FAULT.
- enable_i low in any state -> IDLE next edge: all outputs and counters cleared, fault_o and lost_lock_o cleared.
- BRINGUP: node_enable_o = nodes 0..k. FAULT holds enables 0..k and stops advancing.
- Lock detector, per node, active only while node_enable_o[n]: |err| <= LOCK_THRESH increments counter, saturating at LOCK_CYCLES; otherwise counter clears. locked_o[n] = (counter == LOCK_CYCLES). Disabled node counter = 0.
- |err|: two's complement magnitude; most-negative value maps to 2^(PDET_WIDTH-1), no wrap.
- Weights, all zero for a disabled node:
  - Upstream set U: node 0 {left (reference)}; row 0, c>0 {left}; col 0, r>0 {above}; interior {left, above}.
  - Downstream set D, bidirectional mode only: right if c<COLS-1 and node n+1 enabled; below if r<ROWS-1 and node n+COLS enabled.
  - If D is empty, U shares 4 (4, or 2/2). Otherwise U shares 2 (2, or 1/1) and D shares 2 (2, or 1/1).
- RUN: any locked_o bit falling sets lost_lock_o. FSM stays in RUN; no automatic restart.

## Timing
- Reset: every output 0, state IDLE, all counters 0.
- enable_i sampled high in IDLE: on the next edge state_o=1, active_node_o=0, node_enable_o[0]=1.
- locked_o[n] rises on the edge that registers the LOCK_CYCLES-th consecutive in-window sample. It falls on the edge after the first out-of-window sample.
- Advance: on the edge where locked_o[k] is sampled high, node_enable_o[k+1] rises and the timeout counter clears.
- weights_o are registered from next-state enables and change on the same edge as node_enable_o. A uni_dir_i change is reflected one edge later.
- lost_lock_o is set on the edge after locked_o falls in RUN.
- Simultaneous enable_i low and a lock or timeout event: enable_i wins.
- rst_n_i low mid-operation clears everything immediately.

## Test plan
Common setup: ROWS=COLS=2, PDET_WIDTH=8, LOCK_THRESH=4, LOCK_CYCLES=16, TIMEOUT_CYCLES=200.
- Reset: rst_n_i low with inputs toggling -> all outputs 0, state_o=0.
- Bidirectional bring-up: uni_dir_i=0, all errors 0, enable_i high -> node_enable_o 0001, 0011, 0111, 1111, advancing every 17 cycles. Final weights: n0 {2,0,1,1}, n1 {2,0,0,2}, n2 {0,2,2,0}, n3 {2,2,0,0}; state_o=2; all_locked_o=1.
- Unidirectional bring-up: uni_dir_i=1 -> final weights n0 {4,0,0,0}, n1 {4,0,0,0}, n2 {0,4,0,0}, n3 {2,2,0,0}. With only n0 enabled, n0={4,0,0,0} in both modes.
- Timeout: node 1 error held at 0x20 -> fault_o=1 and state_o=3 exactly 200 cycles after node_enable_o[1] rises; node_enable_o stays 0011.
- Loss of lock in RUN:
  - node 2 error -4 (0xFC) for 1 cycle -> no change.
  - error -5 for 1 cycle -> locked_o[2]=0 next edge, all_locked_o=0, lost_lock_o=1; lost_lock_o stays set after relock.
  - error 0x80 also breaks lock.
- Abort: enable_i low during bring-up of node 2 -> next edge state_o=0 and all outputs 0. Re-enabling restarts from node 0.
